// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to a PS/2
// device on the shared open-drain PS2_CLK/PS2_DAT pins. The full sequence is:
// inhibit, request-to-send, ten device-clocked bits (8 data LSB first, odd
// parity, stop), then the device ACK bit. The result is reported as a one-cycle
// status pulse.
//
// Ports:
//   CLOCK_50      in     system clock, all logic on its rising edge
//   resetn        in     asynchronous active-low reset
//   send_command  in     one-cycle request, samples command_byte (IDLE only)
//   command_byte  in [8] byte to transmit
//   PS2_CLK       inout  open-drain clock, driven 0 or Z
//   PS2_DAT       inout  open-drain data, driven 0 or Z
//   busy          out    high from the cycle after acceptance until back in IDLE
//   command_sent  out    pulse: byte ACKed and bus idle again
//   error_timeout out    pulse: device clock missing
//   error_no_ack  out    pulse: ACK bit sampled high
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | pins released, waiting for send_command
// S_INHIBIT   | PS2_CLK held low to inhibit the device
// S_START     | last clock-low cycle, PS2_DAT pulled low (start bit)
// S_SEND      | clock released, one bit presented per device falling edge
// S_ACK       | data released, device ACK sampled on the next falling edge
// S_WAIT_IDLE | waiting for clock and data both high, then report status
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 5500,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       send_command,
  input  logic [7:0] command_byte,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_sent,
  output logic       error_timeout,
  output logic       error_no_ack
);

  localparam int MAX_TO = (START_TIMEOUT_CYCLES > BIT_TIMEOUT_CYCLES) ?
                          START_TIMEOUT_CYCLES : BIT_TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit_idx;
  logic          r_ok;
  logic          r_clk_low, r_dat_low;
  logic          r_clk_s1, r_clk_s2, r_clk_prev;
  logic          r_dat_s1, r_dat_s2;
  logic          r_busy, r_sent, r_to, r_nack;

  logic          w_fall, w_expire, w_pulse;
  logic [CW-1:0] w_limit, w_cnt_next;

  assign PS2_CLK = r_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = r_dat_low ? 1'b0 : 1'bz;

  assign w_fall  = r_clk_prev & ~r_clk_s2;
  assign w_pulse = r_sent | r_to | r_nack;

  // The long limit only covers the wait for the very first device edge.
  assign w_limit    = (r_state == S_SEND && r_bit_idx == 4'd0) ?
                      CW'(START_TIMEOUT_CYCLES) : CW'(BIT_TIMEOUT_CYCLES);
  assign w_expire   = (r_cnt == w_limit - 1'b1);
  assign w_cnt_next = (r_cnt == w_limit) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_ok       <= 1'b0;
      r_clk_low  <= 1'b0;
      r_dat_low  <= 1'b0;
      // Synchronisers reset to the idle-bus level so no false fall is seen.
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_busy     <= 1'b0;
      r_sent     <= 1'b0;
      r_to       <= 1'b0;
      r_nack     <= 1'b0;
    end else begin
      r_clk_s1   <= PS2_CLK;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= PS2_DAT;
      r_dat_s2   <= r_dat_s1;
      r_sent     <= 1'b0;
      r_to       <= 1'b0;
      r_nack     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A request coinciding with the previous command's status pulse is dropped.
          if (send_command && !w_pulse) begin
            r_shift   <= {1'b1, ~^command_byte, command_byte};
            r_cnt     <= '0;
            r_clk_low <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          // START is the final clock-low cycle, so leave one cycle early.
          if (r_cnt == CW'(INHIBIT_CYCLES - 2)) begin
            r_dat_low <= 1'b1;
            r_state   <= S_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_START: begin
          r_clk_low <= 1'b0;
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (w_fall) begin
            r_dat_low <= ~r_shift[r_bit_idx];
            r_bit_idx <= r_bit_idx + 1'b1;
            r_cnt     <= '0;
            if (r_bit_idx == 4'd9) r_state <= S_ACK;
          end else if (w_expire) begin
            r_clk_low <= 1'b0;
            r_dat_low <= 1'b0;
            r_to      <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        S_ACK: begin
          if (w_fall) begin
            r_ok    <= ~r_dat_s2;
            r_cnt   <= '0;
            r_state <= S_WAIT_IDLE;
          end else if (w_expire) begin
            r_clk_low <= 1'b0;
            r_dat_low <= 1'b0;
            r_to      <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        S_WAIT_IDLE: begin
          if (r_clk_s2 && r_dat_s2) begin
            r_sent  <= r_ok;
            r_nack  <= ~r_ok;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_expire) begin
            r_clk_low <= 1'b0;
            r_dat_low <= 1'b0;
            r_to      <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign command_sent  = r_sent;
  assign error_timeout = r_to;
  assign error_no_ack  = r_nack;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- bench for ps2_host_tx with a simple PS/2 device model.
// Expected status pulses are queued when a command is issued; a monitor pops
// and compares whenever the DUT raises a status pulse.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int STO = 2000;
  localparam int BTO = 500;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       send_command = 1'b0;
  logic [7:0] command_byte = 8'h00;
  logic       busy, command_sent, error_timeout, error_no_ack;
  wire        ps2_clk, ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO), .BIT_TIMEOUT_CYCLES(BTO)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .send_command(send_command),
    .command_byte(command_byte), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .busy(busy), .command_sent(command_sent), .error_timeout(error_timeout),
    .error_no_ack(error_no_ack)
  );

  always #5 clk = ~clk;

  // code: 1 command_sent, 2 error_timeout, 3 error_no_ack
  // rf:   0 no timing check, 1 from clock release, 2 from last device fall
  typedef struct { int code; int rf; int lo; int hi; } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int fall_cyc = 0;
  int run      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Monitor: inhibit length / start bit, and status pulses against the queue.
  always @(negedge clk) begin
    if (resetn) begin
      if (ps2_clk === 1'b0 && !dev_clk_low) run++;
      else if (run > 0) begin
        chk("inhibit_len", run, INH);
        chk("start_bit", int'(ps2_dat), 0);
        rel_cyc = cyc;
        run = 0;
      end
      if (command_sent || error_timeout || error_no_ack) begin
        int got;
        exp_t e;
        got = command_sent ? 1 : (error_timeout ? 2 : 3);
        chk("pulse_onehot", int'(command_sent) + int'(error_timeout) + int'(error_no_ack), 1);
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got status %0d expected none", got);
        end else begin
          e = q.pop_front();
          chk("status", got, e.code);
          chk("busy_at_pulse", int'(busy), 0);
          if (e.rf == 1) chk_rng("timeout_from_release", cyc - rel_cyc, e.lo, e.hi);
          if (e.rf == 2) chk_rng("timeout_from_fall", cyc - fall_cyc, e.lo, e.hi);
          if (got == 2) begin
            chk("to_clk_released", int'(ps2_clk), 1);
            chk("to_dat_released", int'(ps2_dat), 1);
          end
        end
      end
    end else run = 0;
  end

  task automatic push(input int code, input int rf, input int lo, input int hi);
    exp_t e;
    e.code = code; e.rf = rf; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    send_command = 1'b1;
    command_byte = b;
    @(negedge clk);
    send_command = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  // Device: waits for the host request, then gives npulses clock pulses.
  // Pulses 1..10 sample host data on the rising edge; pulse 11 is the ACK.
  task automatic device(input int npulses, input bit drive_ack,
                        input logic [9:0] exp_frame, input bit check_frame);
    logic [9:0] rx;
    int t;
    rx = '0;
    t = 0;
    while (ps2_clk !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    while (ps2_clk !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) begin chk("host_release_seen", 0, 1); return; end
    repeat (30) @(negedge clk);
    for (int i = 0; i < npulses && i < 10; i++) begin
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      rx[i] = ps2_dat;
      repeat (HALF) @(negedge clk);
    end
    if (npulses > 10) begin
      dev_dat_low = drive_ack;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_dat_low = 1'b0;
    end
    if (check_frame) chk("frame", int'(rx), int'(exp_frame));
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 5000) begin @(negedge clk); t++; end
    chk(name, int'(t < 5000), 1);
  endtask

  // {stop, parity, data}: hand-computed odd parity
  localparam logic [9:0] FR_ED = 10'h3ED;  // 6 ones -> parity 1
  localparam logic [9:0] FR_FF = 10'h3FF;  // 8 ones -> parity 1
  localparam logic [9:0] FR_F4 = 10'h2F4;  // 5 ones -> parity 0

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sent", int'(command_sent), 0);
    chk("rst_to", int'(error_timeout), 0);
    chk("rst_nack", int'(error_no_ack), 0);
    chk("rst_clk_z", int'(ps2_clk), 1);
    chk("rst_dat_z", int'(ps2_dat), 1);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Normal 0xED
    push(1, 0, 0, 0);
    send(8'hED);
    device(11, 1'b1, FR_ED, 1'b1);
    wait_done("done_ed");

    // 0xF4 with 0xFF requested in the command_sent cycle: must be ignored
    push(1, 0, 0, 0);
    send(8'hF4);
    device(11, 1'b1, FR_F4, 1'b1);
    begin
      int t;
      t = 0;
      while (!command_sent && t < 2000) begin @(negedge clk); t++; end
      chk("sent_seen_f4", int'(command_sent), 1);
    end
    send_command = 1'b1;
    command_byte = 8'hFF;
    @(negedge clk);
    send_command = 1'b0;
    repeat (200) @(negedge clk);
    chk("ignored_busy", int'(busy), 0);
    chk("ignored_clk_idle", int'(ps2_clk), 1);

    // Re-request 0xFF, then 0xF4
    push(1, 0, 0, 0);
    send(8'hFF);
    device(11, 1'b1, FR_FF, 1'b1);
    wait_done("done_ff");
    push(1, 0, 0, 0);
    send(8'hF4);
    device(11, 1'b1, FR_F4, 1'b1);
    wait_done("done_f4");

    // Device never clocks: timeout exactly STO cycles after release
    push(2, 1, STO, STO);
    send(8'hF4);
    wait_done("done_start_to");

    // Device stops after 5th fall: timeout ~BTO after the registered fall
    push(2, 2, BTO + 1, BTO + 4);
    send(8'hED);
    device(5, 1'b1, FR_ED, 1'b0);
    wait_done("done_bit_to");

    // No ACK: error_no_ack after bus idles
    push(3, 0, 0, 0);
    send(8'hED);
    device(11, 1'b0, FR_ED, 1'b1);
    wait_done("done_noack");

    // Reset during SEND after 4 bits of 0x00 (host is driving data low)
    send(8'h00);
    device(4, 1'b1, 10'h0, 1'b0);
    repeat (5) @(negedge clk);
    chk("dat_low_before_reset", int'(ps2_dat), 0);
    resetn = 1'b0;
    #1;
    chk("reset_clk_z", int'(ps2_clk), 1);
    chk("reset_dat_z", int'(ps2_dat), 1);
    chk("reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);

    push(1, 0, 0, 0);
    send(8'hED);
    device(11, 1'b1, FR_ED, 1'b1);
    wait_done("done_after_reset");

    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
